instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Upstream neighbour of the main control decoder in the single-cycle MIPS core.
//  - Owns the PC and the instruction register (IR).
//  - Fetches each instruction over a ready-based IMEM handshake.
//  - Presents OP/funct to the decoder.
//  - Computes next PC from decoder Branch/Jump plus ALU Zero.
//  - Sequencing: one instruction per EXEC cycle, variable fetch latency, fetch timeout.
// PARAMETERS
//  RESET_PC  32'h0000_3000  PC after reset; bits [1:0] must be 0
//  TIMEOUT   16             max FETCH cycles without imem_ready before HALT (>=1)
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   asynchronous, active-low reset
//  imem_req     out  1   fetch request, high throughout FETCH
//  imem_addr    out  32  word-aligned fetch address (= pc)
//  imem_ready   in   1   imem_rdata valid this cycle
//  imem_rdata   in   32  fetched instruction word
//  Branch       in   1   decoder: instruction is beq
//  Zero         in   1   ALU zero flag
//  Jump         in   1   decoder: ACTIVE-LOW, 0 = jal/j
//  stall        in   1   hold current instruction in EXEC
//  instr        out  32  IR contents
//  OP           out  6   instr[31:26]
//  funct        out  6   instr[5:0]
//  pc           out  32  address of instr
//  pc_plus4     out  32  pc+4 (jal link value)
//  instr_valid  out  1   high in EXEC: decoder outputs are meaningful, commit allowed
//  fetch_err    out  1   sticky, set on timeout
// BEHAVIOUR
//  States: IDLE, FETCH, EXEC, HALT.
//  - Reset (reset=0, async):
//    - state=IDLE, pc=RESET_PC, instr=0.
//    - imem_req=0, instr_valid=0, fetch_err=0, wait counter=0.
//    - Asserting reset mid-FETCH drops imem_req immediately; the pending fetch is discarded.
//  - IDLE: one cycle after reset release, then FETCH.
//  - FETCH:
//    - imem_req=1; imem_addr=pc, held stable.
//    - Wait counter increments each cycle without imem_ready.
//    - imem_ready=1: IR<=imem_rdata, counter<=0, next state EXEC.
//    - Fetch latency is >=1 cycle: ready in the first FETCH cycle gives EXEC next cycle.
//    - Counter reaches TIMEOUT with no ready: fetch_err<=1, go to HALT.
//  - EXEC:
//    - imem_req=0, instr_valid=1.
//    - stall=1: stay in EXEC; IR and pc unchanged.
//    - stall=0: pc<=next_pc, go to FETCH.
//  - HALT: imem_req=0, instr_valid=0, fetch_err=1; exited only by reset.
//  - next_pc (combinational from IR, pc, Branch, Zero, Jump):
//    - Jump==0 (highest priority): {pc_plus4[31:28], instr[25:0], 2'b00}.
//    - else Branch&Zero: pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}.
//    - else: pc_plus4.
//  - All adds are 32-bit modulo 2^32 (wrap, no flag).
//  - Negative offsets are sign-extended.
//  - imem_ready outside FETCH is ignored.
//  - Branch/Jump/Zero are sampled only in the EXEC cycle that has stall=0.
//  - OP, funct, pc_plus4: continuous functions of IR/pc.
// TESTING
//  T1 imem_ready tied 1, release reset:
//     - IDLE 1 cycle, then FETCH with addr 0x3000.
//     - EXEC with pc=0x3000; next FETCH addr 0x3004.
//  T2 beq 0x1000_0003 at pc 0x3008, Branch=1:
//     - Zero=1 -> next pc 0x3018.
//     - Zero=0 -> 0x300C.
//     - offset 0xFFFF with Zero=1 -> 0x3008.
//  T3 jal 0x0C00_0C10 at pc 0x3010, Jump=0, Branch=1, Zero=1:
//     - pc_plus4 = 0x3014.
//     - next pc = 0x3040 (jump wins over branch).
//  T4 imem_ready delayed 3 cycles:
//     - imem_req high 4 FETCH cycles, addr constant.
//     - instr_valid only after ready.
//     - stall=1 for 2 EXEC cycles holds pc/instr.
//  T5 imem_ready never, TIMEOUT=16:
//     - fetch_err=1 and imem_req=0 after 16 FETCH cycles.
//     - Stays in HALT until reset.
//  T6 reset low mid-FETCH, no clock edge:
//     - imem_req=0 and pc=0x3000 immediately.
//     - fetch_err cleared.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC/IR owner with ready-based IMEM fetch, next-PC selection and fetch timeout
`timescale 1ns/1ps

module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int          TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   input  logic        Branch,
   input  logic        Zero,
   input  logic        Jump,
   input  logic        stall,
   output logic [31:0] instr,
   output logic [5:0]  OP,
   output logic [5:0]  funct,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        instr_valid,
   output logic        fetch_err
);

   localparam int            CW        = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] wait_cnt;
   logic [31:0]   ir_q;
   logic [31:0]   pc_q;
   logic          err_q;

   logic          ir_load;
   logic          pc_load;
   logic          cnt_inc;
   logic          cnt_clr;
   logic          err_set;

   logic [31:0]   branch_off;
   logic [31:0]   jump_tgt;
   logic [31:0]   next_pc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n     = state;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      ir_load     = 1'b0;
      pc_load     = 1'b0;
      cnt_inc     = 1'b0;
      cnt_clr     = 1'b0;
      err_set     = 1'b0;
      case (state)
         IDLE: begin
            state_n = FETCH;
         end
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_load = 1'b1;
               cnt_clr = 1'b1;
               state_n = EXEC;
            end else if (wait_cnt == WAIT_LAST) begin
               // this is the TIMEOUT-th cycle with no response
               err_set = 1'b1;
               cnt_clr = 1'b1;
               state_n = HALT;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         EXEC: begin
            instr_valid = 1'b1;
            if (!stall) begin
               pc_load = 1'b1;
               state_n = FETCH;
            end
         end
         HALT: begin
            state_n = HALT;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign pc_plus4   = pc_q + 32'd4;
   assign branch_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
   assign jump_tgt   = {pc_plus4[31:28], ir_q[25:0], 2'b00};

   // Jump is active-low and outranks a taken branch
   always_comb begin
      next_pc = pc_plus4;
      if (!Jump) begin
         next_pc = jump_tgt;
      end else if (Branch && Zero) begin
         next_pc = pc_plus4 + branch_off;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q <= RESET_PC;
      end else if (pc_load) begin
         pc_q <= next_pc;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ir_q <= 32'd0;
      end else if (ir_load) begin
         ir_q <= imem_rdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt <= '0;
      end else if (cnt_clr) begin
         wait_cnt <= '0;
      end else if (cnt_inc) begin
         wait_cnt <= wait_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else if (err_set) begin
         err_q <= 1'b1;
      end
   end

   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign instr     = ir_q;
   assign OP        = ir_q[31:26];
   assign funct     = ir_q[5:0];
   assign fetch_err = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed-vector bench for instr_fetch_unit
`timescale 1ns/1ps

module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        Branch;
   logic        Zero;
   logic        Jump;
   logic        stall;
   logic [31:0] instr;
   logic [5:0]  OP;
   logic [5:0]  funct;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        instr_valid;
   logic        fetch_err;

   int vectors     = 0;
   int miscompares = 0;

   instr_fetch_unit dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .Branch      (Branch),
      .Zero        (Zero),
      .Jump        (Jump),
      .stall       (stall),
      .instr       (instr),
      .OP          (OP),
      .funct       (funct),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .instr_valid (instr_valid),
      .fetch_err   (fetch_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Entered at a negedge with the DUT in FETCH; leaves at a negedge in EXEC.
   task automatic fetch(input logic [31:0] addr, input logic [31:0] word, input int delay);
      imem_ready = 1'b0;
      for (int i = 0; i < delay; i++) begin
         chk("wait_req", 32'(imem_req), 32'd1);
         chk("wait_addr", imem_addr, addr);
         chk("wait_nvalid", 32'(instr_valid), 32'd0);
         @(negedge clk);
      end
      chk("fetch_req", 32'(imem_req), 32'd1);
      chk("fetch_addr", imem_addr, addr);
      imem_ready = 1'b1;
      imem_rdata = word;
      @(negedge clk);
      imem_ready = 1'b0;
      imem_rdata = 32'hA5A5_5A5A;
      chk("exec_valid", 32'(instr_valid), 32'd1);
      chk("exec_instr", instr, word);
      chk("exec_pc", pc, addr);
      chk("exec_req", 32'(imem_req), 32'd0);
   endtask

   // Entered at a negedge in EXEC; commits and checks the resulting fetch address.
   task automatic exec(input logic br, input logic z, input logic jp, input logic [31:0] exp_next);
      Branch = br;
      Zero   = z;
      Jump   = jp;
      stall  = 1'b0;
      @(negedge clk);
      Branch = 1'b0;
      Zero   = 1'b0;
      Jump   = 1'b1;
      chk("next_pc", pc, exp_next);
      chk("next_addr", imem_addr, exp_next);
      chk("next_req", 32'(imem_req), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b0;
      imem_ready = 1'b0;
      imem_rdata = 32'd0;
      Branch     = 1'b0;
      Zero       = 1'b0;
      Jump       = 1'b1;
      stall      = 1'b0;

      #12;
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_pc", pc, 32'h0000_3000);
      chk("rst_instr", instr, 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_err", 32'(fetch_err), 32'd0);
      chk("rst_pc4", pc_plus4, 32'h0000_3004);

      // T1: sequential fetch with immediate ready
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("idle_req", 32'(imem_req), 32'd0);
      @(negedge clk);
      fetch(32'h0000_3000, 32'h0000_0020, 0);
      chk("op_add", 32'(OP), 32'd0);
      chk("funct_add", 32'(funct), 32'h20);
      exec(1'b0, 1'b0, 1'b1, 32'h0000_3004);
      fetch(32'h0000_3004, 32'h0000_0000, 0);
      exec(1'b0, 1'b0, 1'b1, 32'h0000_3008);

      // T2: beq taken, jump back, negative offset, not-taken
      fetch(32'h0000_3008, 32'h1000_0003, 0);
      chk("op_beq", 32'(OP), 32'd4);
      exec(1'b1, 1'b1, 1'b1, 32'h0000_3018);
      fetch(32'h0000_3018, 32'h0800_0C02, 0);
      exec(1'b0, 1'b0, 1'b0, 32'h0000_3008);
      fetch(32'h0000_3008, 32'h1000_FFFF, 0);
      exec(1'b1, 1'b1, 1'b1, 32'h0000_3008);
      fetch(32'h0000_3008, 32'h1000_0003, 0);
      exec(1'b1, 1'b0, 1'b1, 32'h0000_300C);
      fetch(32'h0000_300C, 32'h0000_0000, 0);
      exec(1'b0, 1'b0, 1'b1, 32'h0000_3010);

      // T3: jal wins over taken branch
      fetch(32'h0000_3010, 32'h0C00_0C10, 0);
      chk("jal_pc4", pc_plus4, 32'h0000_3014);
      chk("op_jal", 32'(OP), 32'd3);
      chk("funct_jal", 32'(funct), 32'h10);
      exec(1'b1, 1'b1, 1'b0, 32'h0000_3040);

      // T4: delayed ready, then two stall cycles with stray ready
      fetch(32'h0000_3040, 32'h2108_0001, 3);
      stall      = 1'b1;
      Jump       = 1'b0;
      imem_ready = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("stall_valid", 32'(instr_valid), 32'd1);
         chk("stall_pc", pc, 32'h0000_3040);
         chk("stall_instr", instr, 32'h2108_0001);
         chk("stall_req", 32'(imem_req), 32'd0);
      end
      imem_ready = 1'b0;
      exec(1'b0, 1'b0, 1'b1, 32'h0000_3044);

      // T5: no ready ever -> HALT after TIMEOUT cycles
      for (int i = 0; i < 16; i++) begin
         chk("to_req", 32'(imem_req), 32'd1);
         chk("to_err", 32'(fetch_err), 32'd0);
         chk("to_addr", imem_addr, 32'h0000_3044);
         @(negedge clk);
      end
      chk("halt_err", 32'(fetch_err), 32'd1);
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_valid", 32'(instr_valid), 32'd0);
      imem_ready = 1'b1;
      repeat (5) @(negedge clk);
      imem_ready = 1'b0;
      chk("halt_stay_err", 32'(fetch_err), 32'd1);
      chk("halt_stay_req", 32'(imem_req), 32'd0);
      chk("halt_stay_valid", 32'(instr_valid), 32'd0);
      chk("halt_stay_pc", pc, 32'h0000_3044);

      // T6: asynchronous reset, first from HALT, then mid-FETCH
      #2;
      reset = 1'b0;
      #1;
      chk("arst_err", 32'(fetch_err), 32'd0);
      chk("arst_req", 32'(imem_req), 32'd0);
      chk("arst_pc", pc, 32'h0000_3000);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      fetch(32'h0000_3000, 32'h0000_0000, 0);
      exec(1'b0, 1'b0, 1'b1, 32'h0000_3004);
      @(negedge clk);
      chk("mid_req", 32'(imem_req), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_req", 32'(imem_req), 32'd0);
      chk("mid_rst_pc", pc, 32'h0000_3000);
      chk("mid_rst_instr", instr, 32'd0);
      chk("mid_rst_valid", 32'(instr_valid), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      fetch(32'h0000_3000, 32'h0000_0025, 1);
      chk("post_funct", 32'(funct), 32'h25);
      exec(1'b0, 1'b0, 1'b1, 32'h0000_3004);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
